// File: rtl/core_scheduler_pkg.sv
// Shared core-state encoding used by the scheduler, ALUs, LSUs and PC units.
// Every unit decodes the broadcast state against these constants.
package core_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_FETCH   = 3'b001,
    ST_DECODE  = 3'b010,
    ST_REQUEST = 3'b011,
    ST_WAIT    = 3'b100,
    ST_EXECUTE = 3'b101,
    ST_UPDATE  = 3'b110,
    ST_DONE    = 3'b111
  } core_state_t;

endpackage

// File: rtl/core_scheduler_pc_select.sv
// Picks the next PC from the lowest enabled lane and flags lanes that
// disagree with it.
module pc_select #(
  parameter int THREADS  = 4,
  parameter int PC_WIDTH = 8
) (
  input  logic [THREADS-1:0]          i_enable,
  input  logic [THREADS*PC_WIDTH-1:0] i_next_pc,
  output logic [PC_WIDTH-1:0]         o_sel_pc,
  output logic                        o_any_en,
  output logic                        o_diverged
);

  logic [PC_WIDTH-1:0] w_sel;
  logic                w_div;

  // Scan high-to-low so the lowest enabled lane wins.
  always_comb begin
    w_sel = '0;
    for (int i = THREADS - 1; i >= 0; i--) begin
      if (i_enable[i]) begin
        w_sel = i_next_pc[i*PC_WIDTH +: PC_WIDTH];
      end
    end
  end

  always_comb begin
    w_div = 1'b0;
    for (int i = 0; i < THREADS; i++) begin
      if (i_enable[i] &&
          i_next_pc[i*PC_WIDTH +: PC_WIDTH] != w_sel) begin
        w_div = 1'b1;
      end
    end
  end

  assign o_sel_pc   = w_sel;
  assign o_any_en   = |i_enable;
  assign o_diverged = w_div;

endmodule

// File: rtl/core_scheduler.sv
// Per-core instruction sequencer: steps one warp of lanes through
// fetch/decode/memory/execute/update and tracks retirement.
module core_scheduler
  import core_scheduler_pkg::*;
#(
  parameter int THREADS   = 4,
  parameter int PC_WIDTH  = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [THREADS-1:0]          thread_enable,
  input  logic                        instr_valid,
  input  logic [THREADS-1:0]          lsu_busy,
  input  logic                        decoded_ret,
  input  logic [THREADS*PC_WIDTH-1:0] next_pc,
  output logic [2:0]                  core_state,
  output logic [PC_WIDTH-1:0]         current_pc,
  output logic                        fetch_req,
  output logic                        done,
  output logic                        pc_diverged,
  output logic [CNT_WIDTH-1:0]        instr_count
);

  core_state_t          r_state;
  logic [PC_WIDTH-1:0]  r_pc;
  logic                 r_done;
  logic                 r_div;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic [PC_WIDTH-1:0]  w_sel_pc;
  logic                 w_any_en;
  logic                 w_diverged;
  logic                 w_busy;

  pc_select #(
    .THREADS  (THREADS),
    .PC_WIDTH (PC_WIDTH)
  ) u_pc_select (
    .i_enable   (thread_enable),
    .i_next_pc  (next_pc),
    .o_sel_pc   (w_sel_pc),
    .o_any_en   (w_any_en),
    .o_diverged (w_diverged)
  );

  // Busy bits from disabled lanes must not stall the core.
  assign w_busy = |(lsu_busy & thread_enable);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_done  <= 1'b0;
      r_div   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_FETCH;
            r_pc    <= '0;
            r_done  <= 1'b0;
            r_div   <= 1'b0;
            r_cnt   <= '0;
          end
        end
        ST_FETCH: begin
          if (instr_valid) r_state <= ST_DECODE;
        end
        ST_DECODE:  r_state <= ST_REQUEST;
        ST_REQUEST: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (!w_busy) r_state <= ST_EXECUTE;
        end
        ST_EXECUTE: r_state <= ST_UPDATE;
        ST_UPDATE: begin
          if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
          if (w_diverged) r_div <= 1'b1;
          if (decoded_ret || !w_any_en) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_pc    <= w_sel_pc;
            r_state <= ST_FETCH;
          end
        end
        ST_DONE: r_state <= ST_DONE;
      endcase
    end
  end

  assign core_state  = r_state;
  assign current_pc  = r_pc;
  assign fetch_req   = (r_state == ST_FETCH);
  assign done        = r_done;
  assign pc_diverged = r_div;
  assign instr_count = r_cnt;

endmodule

// File: tb/tb_core_scheduler.sv
// Directed bench for core_scheduler; a narrow-counter instance shares
// the stimulus to exercise retirement-count saturation.
module tb_core_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  thread_enable;
  logic        instr_valid;
  logic [3:0]  lsu_busy;
  logic        decoded_ret;
  logic [31:0] next_pc;

  logic [2:0]  core_state;
  logic [7:0]  current_pc;
  logic        fetch_req;
  logic        done;
  logic        pc_diverged;
  logic [15:0] instr_count;

  logic [2:0]  s_state;
  logic [7:0]  s_pc;
  logic        s_fetch;
  logic        s_done;
  logic        s_div;
  logic [1:0]  s_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  core_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .thread_enable (thread_enable),
    .instr_valid   (instr_valid),
    .lsu_busy      (lsu_busy),
    .decoded_ret   (decoded_ret),
    .next_pc       (next_pc),
    .core_state    (core_state),
    .current_pc    (current_pc),
    .fetch_req     (fetch_req),
    .done          (done),
    .pc_diverged   (pc_diverged),
    .instr_count   (instr_count)
  );

  core_scheduler #(.CNT_WIDTH(2)) dut_sat (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .thread_enable (thread_enable),
    .instr_valid   (instr_valid),
    .lsu_busy      (lsu_busy),
    .decoded_ret   (decoded_ret),
    .next_pc       (next_pc),
    .core_state    (s_state),
    .current_pc    (s_pc),
    .fetch_req     (s_fetch),
    .done          (s_done),
    .pc_diverged   (s_div),
    .instr_count   (s_cnt)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until the core is back in FETCH or reaches DONE.
  task automatic run_instr();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(core_state == 3'd1 || core_state == 3'd7) && n < 20);
    check("run_bound", 32'(n < 20), 32'd1);
  endtask

  logic [2:0] exp_seq [7];
  int waits;

  initial begin
    exp_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1};
    reset = 1'b1;
    start = 1'b0;
    thread_enable = 4'b1111;
    instr_valid = 1'b1;
    lsu_busy = 4'b0000;
    decoded_ret = 1'b0;
    next_pc = {8'd1, 8'd1, 8'd1, 8'd1};
    step();
    step();
    reset = 1'b0;
    check("rst_state", 32'(core_state), 32'd0);
    check("rst_pc", 32'(current_pc), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_div", 32'(pc_diverged), 32'd0);
    check("rst_cnt", 32'(instr_count), 32'd0);
    check("rst_fetch", 32'(fetch_req), 32'd0);

    // Basic instruction sequence.
    start = 1'b1;
    step();
    start = 1'b0;
    check("seq0", 32'(core_state), 32'(exp_seq[0]));
    check("seq0_fetch", 32'(fetch_req), 32'd1);
    for (int i = 1; i < 7; i++) begin
      step();
      check($sformatf("seq%0d", i), 32'(core_state),
            32'(exp_seq[i]));
    end
    check("seq_pc", 32'(current_pc), 32'd1);
    check("seq_cnt", 32'(instr_count), 32'd1);

    // FETCH stall.
    instr_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d", i), 32'(core_state), 32'd1);
      check($sformatf("stall_req%0d", i), 32'(fetch_req), 32'd1);
      step();
    end
    check("stall_last", 32'(core_state), 32'd1);
    check("stall_last_req", 32'(fetch_req), 32'd1);
    instr_valid = 1'b1;
    step();
    check("stall_exit", 32'(core_state), 32'd2);

    // WAIT held by an enabled busy lane.
    lsu_busy = 4'b0100;
    step();
    check("req_state", 32'(core_state), 32'd3);
    step();
    waits = 0;
    for (int k = 0; k < 10 && core_state == 3'd4; k++) begin
      waits++;
      if (waits == 3) lsu_busy = 4'b0000;
      step();
    end
    check("wait_cycles", 32'(waits), 32'd3);
    check("wait_exit", 32'(core_state), 32'd5);
    step();
    check("upd_state", 32'(core_state), 32'd6);
    step();
    check("w1_cnt", 32'(instr_count), 32'd2);

    // Busy on a disabled lane is ignored.
    thread_enable = 4'b1011;
    lsu_busy = 4'b0100;
    step();
    step();
    step();
    waits = 0;
    for (int k = 0; k < 10 && core_state == 3'd4; k++) begin
      waits++;
      step();
    end
    check("wait_mask", 32'(waits), 32'd1);
    check("wait_mask_exit", 32'(core_state), 32'd5);
    lsu_busy = 4'b0000;
    step();
    step();
    check("w2_state", 32'(core_state), 32'd1);
    check("w2_cnt", 32'(instr_count), 32'd3);

    // Divergence, lowest enabled lane selection.
    thread_enable = 4'b1110;
    next_pc = {8'd9, 8'd9, 8'd7, 8'd3};
    run_instr();
    check("div_pc", 32'(current_pc), 32'd7);
    check("div_flag", 32'(pc_diverged), 32'd1);
    check("div_cnt", 32'(instr_count), 32'd4);
    check("sat_cnt4", 32'(s_cnt), 32'd3);
    next_pc = {8'd9, 8'd9, 8'd9, 8'd9};
    run_instr();
    check("sticky_pc", 32'(current_pc), 32'd9);
    check("sticky_div", 32'(pc_diverged), 32'd1);
    check("cnt5", 32'(instr_count), 32'd5);
    check("sat_cnt5", 32'(s_cnt), 32'd3);

    // Fresh run with uniform PCs.
    reset = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("rs_state", 32'(core_state), 32'd1);
    check("rs_cnt", 32'(instr_count), 32'd0);
    run_instr();
    check("uni_pc", 32'(current_pc), 32'd9);
    check("uni_div", 32'(pc_diverged), 32'd0);
    check("uni_cnt", 32'(instr_count), 32'd1);

    // RET ends the program.
    decoded_ret = 1'b1;
    run_instr();
    decoded_ret = 1'b0;
    check("ret_state", 32'(core_state), 32'd7);
    check("ret_done", 32'(done), 32'd1);
    check("ret_pc", 32'(current_pc), 32'd9);
    check("ret_cnt", 32'(instr_count), 32'd2);
    for (int i = 0; i < 4; i++) begin
      start = ~start;
      step();
      check($sformatf("done_hold%0d", i), 32'(core_state), 32'd7);
      check($sformatf("done_flag%0d", i), 32'(done), 32'd1);
    end
    start = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("r2_state", 32'(core_state), 32'd0);
    check("r2_pc", 32'(current_pc), 32'd0);
    check("r2_done", 32'(done), 32'd0);
    check("r2_div", 32'(pc_diverged), 32'd0);
    check("r2_cnt", 32'(instr_count), 32'd0);
    check("r2_fetch", 32'(fetch_req), 32'd0);

    // No enabled lanes in UPDATE also ends the program.
    thread_enable = 4'b0000;
    start = 1'b1;
    step();
    start = 1'b0;
    run_instr();
    check("noen_state", 32'(core_state), 32'd7);
    check("noen_done", 32'(done), 32'd1);
    check("noen_pc", 32'(current_pc), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;

    // Reset while stalled in WAIT.
    thread_enable = 4'b1111;
    lsu_busy = 4'b1111;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    step();
    step();
    check("stuck_wait", 32'(core_state), 32'd4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("wrst_state", 32'(core_state), 32'd0);
    check("wrst_cnt", 32'(instr_count), 32'd0);
    check("wrst_pc", 32'(current_pc), 32'd0);
    step();
    check("wrst_idle", 32'(core_state), 32'd0);
    lsu_busy = 4'b0000;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
